serial_add_seq: RTL and testbench

- Multi-cycle WIDTH-bit adder that reuses one bit2adder slice (2 bits/cycle, ripple carry held in a flop) to add two WIDTH-bit operands.
- Sequences the slice LSB-first.
- Start/busy/done handshake toward the lab top level.
- Trades area for latency: one 2-bit adder serves any even WIDTH.

---
 rtl/serial_add_seq_pkg.sv | 18 +
 rtl/bit2adder.sv | 22 ++
 rtl/serial_add_seq.sv | 117 +++++++++++
 tb/tb_serial_add_seq.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_seq_pkg.sv
// Purpose: shared sequencer definitions (state encoding, counter sizing helper).
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: ST_IDLE/ST_RUN/ST_DONE state constants, cnt_width() helper.
package serial_add_seq_pkg;

  // Controller state encoding, shared with later lab sequencers.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Slice counter width. The extra bit keeps the counter from wrapping
  // even when NSLICE is an exact power of two.
  function automatic int cnt_width(input int nslice);
    return $clog2(nslice) + 1;
  endfunction

endpackage

// File: rtl/bit2adder.sv
// Purpose: 2-bit ripple-carry adder slice (combinational).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: a0/a1, b0/b1 operand bits (LSB first), cin carry-in;
//        s0/s1 sum bits, cout carry-out of bit 1.
module bit2adder (
  input  logic a0,
  input  logic a1,
  input  logic b0,
  input  logic b1,
  input  logic cin,
  output logic s0,
  output logic s1,
  output logic cout
);

  logic w_c0;

  assign {w_c0, s0} = {1'b0, a0} + {1'b0, b0} + {1'b0, cin};
  assign {cout, s1} = {1'b0, a1} + {1'b0, b1} + {1'b0, w_c0};

endmodule

// File: rtl/serial_add_seq.sv
// Purpose: WIDTH-bit adder built from one reused 2-bit slice, LSB pair first.
// Latency: start accepted at edge t -> busy for NSLICE cycles -> done pulse after edge t+NSLICE.
// Backpressure: start is only sampled in IDLE; start during RUN/DONE is ignored.
// Ports: clk, rst (sync, active-high); start, a, b, cin (captured on accept);
//        busy (RUN), done (1-cycle result pulse), sum/cout (held until next completion).
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / 2;
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  // The slice consumes two bits per cycle, so odd or tiny widths cannot work.
  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_add_seq: WIDTH must be even and >= 2");
  end

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s0;
  logic             w_s1;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  bit2adder u_slice (
    .a0   (r_a_sh[0]),
    .a1   (r_a_sh[1]),
    .b0   (r_b_sh[0]),
    .b1   (r_b_sh[1]),
    .cin  (r_carry),
    .s0   (w_s0),
    .s1   (w_s1),
    .cout (w_slice_cout)
  );

  // New slice bits enter at the top; after NSLICE shifts the first slice
  // has walked down to bit 0, so the accumulator is the finished sum.
  if (WIDTH == 2) begin : g_acc_w2
    assign w_acc_next = {w_s1, w_s0};
  end else begin : g_acc_wide
    assign w_acc_next = {w_s1, w_s0, r_acc[WIDTH-1:2]};
  end

  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a_sh  <= r_a_sh >> 2;
          r_b_sh  <= r_b_sh >> 2;
          r_carry <= w_slice_cout;
          r_acc   <= w_acc_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          // Publish only on the final slice so sum/cout never show partials.
          if (w_last) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_slice_cout;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_seq.sv
// Purpose: self-checking bench for serial_add_seq at WIDTH 8, 2 and 16.
// Latency: checks busy/done timing against start acceptance.
// Backpressure: exercises start held or raised while the adder is busy.
module tb_serial_add_seq;

  logic clk;
  logic rst;

  // Index 0: WIDTH=8, index 1: WIDTH=2, index 2: WIDTH=16.
  logic        start_v [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic        cin_v   [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] sum_v   [3];
  logic        cout_v  [3];

  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy2, done2, cout2;
  logic [1:0]  sum2;
  logic        busy16, done16, cout16;
  logic [15:0] sum16;

  int n_checks;
  int n_errors;

  serial_add_seq #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start_v[0]),
    .a     (a_v[0][7:0]),
    .b     (b_v[0][7:0]),
    .cin   (cin_v[0]),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_add_seq #(.WIDTH(2)) u_dut2 (
    .clk   (clk),
    .rst   (rst),
    .start (start_v[1]),
    .a     (a_v[1][1:0]),
    .b     (b_v[1][1:0]),
    .cin   (cin_v[1]),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  serial_add_seq #(.WIDTH(16)) u_dut16 (
    .clk   (clk),
    .rst   (rst),
    .start (start_v[2]),
    .a     (a_v[2]),
    .b     (b_v[2]),
    .cin   (cin_v[2]),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16)
  );

  assign busy_v[0] = busy8;
  assign done_v[0] = done8;
  assign sum_v[0]  = {8'h00, sum8};
  assign cout_v[0] = cout8;
  assign busy_v[1] = busy2;
  assign done_v[1] = done2;
  assign sum_v[1]  = {14'h0000, sum2};
  assign cout_v[1] = cout2;
  assign busy_v[2] = busy16;
  assign done_v[2] = done16;
  assign sum_v[2]  = sum16;
  assign cout_v[2] = cout16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int width_of(input int sel);
    if (sel == 0) return 8;
    if (sel == 1) return 2;
    return 16;
  endfunction

  // Reference: plain integer addition truncated to WIDTH+1 bits.
  function automatic logic [16:0] ref_add(input int sel, input logic [15:0] a,
                                          input logic [15:0] b, input logic ci);
    int          w;
    logic [16:0] mask;
    logic [16:0] full;
    w    = width_of(sel);
    mask = (17'h1 << w) - 17'h1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {16'h0000, ci};
    return full & ((17'h1 << (w + 1)) - 17'h1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation on one DUT: checks busy window, single done pulse, result.
  // start is raised again during RUN and DONE and operands are scrambled
  // after acceptance; neither may disturb the result.
  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input string name);
    int          ns;
    int          w;
    logic [16:0] exp;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic [15:0] held_sum;
    logic        held_cout;
    w         = width_of(sel);
    ns        = w / 2;
    exp       = ref_add(sel, a, b, ci);
    exp_sum   = exp[15:0] & 16'((17'h1 << w) - 17'h1);
    exp_cout  = exp[w];
    held_sum  = sum_v[sel];
    held_cout = cout_v[sel];

    start_v[sel] = 1'b1;
    a_v[sel]     = a;
    b_v[sel]     = b;
    cin_v[sel]   = ci;
    tick();
    a_v[sel]   = 16'($urandom);
    b_v[sel]   = 16'($urandom);
    cin_v[sel] = ~ci;
    for (int i = 0; i < ns; i++) begin
      start_v[sel] = 1'($urandom_range(0, 1));
      n_checks++;
      if (busy_v[sel] !== 1'b1 || done_v[sel] !== 1'b0) begin
        n_errors++;
        $display("FAIL %s run cycle %0d: busy=%b done=%b, need busy=1 done=0",
                 name, i, busy_v[sel], done_v[sel]);
      end
      n_checks++;
      if (sum_v[sel] !== held_sum || cout_v[sel] !== held_cout) begin
        n_errors++;
        $display("FAIL %s held result cycle %0d: got %b/%h, need %b/%h",
                 name, i, cout_v[sel], sum_v[sel], held_cout, held_sum);
      end
      tick();
    end
    start_v[sel] = 1'b1;
    n_checks++;
    if (done_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0) begin
      n_errors++;
      $display("FAIL %s done pulse: busy=%b done=%b, need busy=0 done=1",
               name, busy_v[sel], done_v[sel]);
    end
    n_checks++;
    if (sum_v[sel] !== exp_sum || cout_v[sel] !== exp_cout) begin
      n_errors++;
      $display("FAIL %s result a=%h b=%h cin=%b: got cout=%b sum=%h, need cout=%b sum=%h",
               name, a, b, ci, cout_v[sel], sum_v[sel], exp_cout, exp_sum);
    end
    tick();
    start_v[sel] = 1'b0;
    n_checks++;
    if (done_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0 ||
        sum_v[sel] !== exp_sum || cout_v[sel] !== exp_cout) begin
      n_errors++;
      $display("FAIL %s after done: busy=%b done=%b cout=%b sum=%h, need 0/0/%b/%h",
               name, busy_v[sel], done_v[sel], cout_v[sel], sum_v[sel], exp_cout, exp_sum);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (busy_v[s] !== 1'b0 || done_v[s] !== 1'b0 || sum_v[s] !== 16'h0000 ||
          cout_v[s] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset dut%0d: busy=%b done=%b cout=%b sum=%h, need all zero",
                 s, busy_v[s], done_v[s], cout_v[s], sum_v[s]);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero();
    do_op(0, 16'h0000, 16'h0000, 1'b0, "zero8");
  endtask

  task automatic test_carry_chain();
    do_op(0, 16'h00FF, 16'h0001, 1'b0, "ff_plus_1");
    do_op(0, 16'h00A5, 16'h005A, 1'b1, "a5_5a_cin");
  endtask

  // start held high across a whole op with operands changed mid-run.
  task automatic test_start_held();
    start_v[0] = 1'b1;
    a_v[0]     = 16'h0012;
    b_v[0]     = 16'h0034;
    cin_v[0]   = 1'b0;
    tick();
    a_v[0] = 16'h00FF;
    b_v[0] = 16'h00FF;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (busy_v[0] !== 1'b1) begin
        n_errors++;
        $display("FAIL held_start busy cycle %0d: got %b, need 1", i, busy_v[0]);
      end
      tick();
    end
    n_checks++;
    if (done_v[0] !== 1'b1 || sum_v[0] !== 16'h0046 || cout_v[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL held_start result: done=%b cout=%b sum=%h, need 1/0/0046",
               done_v[0], cout_v[0], sum_v[0]);
    end
    tick();
    n_checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL held_start idle gap: busy=%b done=%b, need 0/0",
               busy_v[0], done_v[0]);
    end
    tick();
    start_v[0] = 1'b0;
    n_checks++;
    if (busy_v[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL held_start restart: busy=%b, need 1", busy_v[0]);
    end
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (done_v[0] !== 1'b1 || sum_v[0] !== 16'h00FE || cout_v[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL held_start second op: done=%b cout=%b sum=%h, need 1/1/00fe",
               done_v[0], cout_v[0], sum_v[0]);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    start_v[0] = 1'b1;
    a_v[0]     = 16'h007F;
    b_v[0]     = 16'h0001;
    cin_v[0]   = 1'b0;
    tick();
    start_v[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || sum_v[0] !== 16'h0000 ||
        cout_v[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_run_reset: busy=%b done=%b cout=%b sum=%h, need all zero",
               busy_v[0], done_v[0], cout_v[0], sum_v[0]);
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_errors++;
      $display("FAIL mid_run_reset activity: %0d busy/done cycles, need 0", pulses);
    end
  endtask

  task automatic test_w2_exhaustive();
    logic [4:0] v;
    for (int k = 0; k < 32; k++) begin
      v = 5'(k);
      do_op(1, {14'h0000, v[4:3]}, {14'h0000, v[2:1]}, v[0], "w2_exh");
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++)
      do_op(0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), "b2b8");
  endtask

  task automatic test_w16_random();
    for (int k = 0; k < 200; k++)
      do_op(2, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "rand16");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    for (int s = 0; s < 3; s++) begin
      start_v[s] = 1'b0;
      a_v[s]     = 16'h0000;
      b_v[s]     = 16'h0000;
      cin_v[s]   = 1'b0;
    end
    test_reset();
    test_zero();
    test_carry_chain();
    test_start_held();
    test_reset_mid_run();
    test_w2_exhaustive();
    test_back_to_back();
    test_w16_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
